// File: rtl/project_select_ctrl.sv
// rtl/project_select_ctrl.sv - per-project reset vector generator with settle window on every project switch
module project_select_ctrl #(
    parameter int NUM_PROJECTS  = 4,
    parameter int SETTLE_CYCLES = 8,
    parameter int ID_W          = $clog2(NUM_PROJECTS)
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    sel_valid,
    input  logic [ID_W-1:0]         sel_id,
    output logic                    sel_ready,
    output logic [NUM_PROJECTS-1:0] proj_reset,
    output logic                    active_valid,
    output logic [ID_W-1:0]         active_id,
    output logic                    busy,
    output logic                    sel_err
);
    localparam int CNT_W = $clog2(SETTLE_CYCLES + 1);

    typedef enum logic [1:0] {
        IDLE,
        SWITCH,
        RUN
    } state_t;

    state_t                  state, state_n;
    logic [CNT_W-1:0]        cnt, cnt_n;
    logic [ID_W-1:0]         id_q, id_n;
    logic [NUM_PROJECTS-1:0] proj_reset_n;
    logic                    active_valid_n;
    logic [ID_W-1:0]         active_id_n;
    logic                    busy_n;
    logic                    sel_err_n;
    logic                    accept;
    logic                    id_in_range;

    assign sel_ready   = (state != SWITCH);
    assign accept      = sel_valid && sel_ready;
    assign id_in_range = 32'(sel_id) < 32'(NUM_PROJECTS);

    always_comb begin
        state_n        = state;
        cnt_n          = cnt;
        id_n           = id_q;
        proj_reset_n   = proj_reset;
        active_valid_n = active_valid;
        active_id_n    = active_id;
        busy_n         = busy;
        sel_err_n      = 1'b0;
        case (state)
            IDLE, RUN: begin
                // Re-selecting the running project still takes the full settle path.
                if (accept) begin
                    proj_reset_n   = '1;
                    active_valid_n = 1'b0;
                    if (id_in_range) begin
                        id_n    = sel_id;
                        busy_n  = 1'b1;
                        cnt_n   = CNT_W'(SETTLE_CYCLES - 1);
                        state_n = SWITCH;
                    end else begin
                        sel_err_n = 1'b1;
                        state_n   = IDLE;
                    end
                end
            end
            SWITCH: begin
                if (cnt == '0) begin
                    for (int i = 0; i < NUM_PROJECTS; i++) begin
                        proj_reset_n[i] = (ID_W'(i) != id_q);
                    end
                    active_valid_n = 1'b1;
                    active_id_n    = id_q;
                    busy_n         = 1'b0;
                    state_n        = RUN;
                end else begin
                    cnt_n = cnt - CNT_W'(1);
                end
            end
            default: begin
                proj_reset_n   = '1;
                active_valid_n = 1'b0;
                busy_n         = 1'b0;
                state_n        = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= IDLE;
            cnt          <= '0;
            id_q         <= '0;
            proj_reset   <= '1;
            active_valid <= 1'b0;
            active_id    <= '0;
            busy         <= 1'b0;
            sel_err      <= 1'b0;
        end else begin
            state        <= state_n;
            cnt          <= cnt_n;
            id_q         <= id_n;
            proj_reset   <= proj_reset_n;
            active_valid <= active_valid_n;
            active_id    <= active_id_n;
            busy         <= busy_n;
            sel_err      <= sel_err_n;
        end
    end
endmodule

// File: tb/tb_project_select_ctrl.sv
// tb/tb_project_select_ctrl.sv - self-checking bench for project_select_ctrl
module tb_project_select_ctrl;
    localparam int S = 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset;
    logic       sel_valid;
    logic [1:0] sel_id;
    logic       sel_ready;
    logic [3:0] proj_reset;
    logic       active_valid;
    logic [1:0] active_id;
    logic       busy;
    logic       sel_err;

    logic       reset3;
    logic       sel_valid3;
    logic [1:0] sel_id3;
    logic       sel_ready3;
    logic [2:0] proj_reset3;
    logic       active_valid3;
    logic [1:0] active_id3;
    logic       busy3;
    logic       sel_err3;

    project_select_ctrl #(.NUM_PROJECTS(4), .SETTLE_CYCLES(S)) dut (
        .clk(clk), .reset(reset), .sel_valid(sel_valid), .sel_id(sel_id),
        .sel_ready(sel_ready), .proj_reset(proj_reset), .active_valid(active_valid),
        .active_id(active_id), .busy(busy), .sel_err(sel_err)
    );

    project_select_ctrl #(.NUM_PROJECTS(3), .SETTLE_CYCLES(S)) dut3 (
        .clk(clk), .reset(reset3), .sel_valid(sel_valid3), .sel_id(sel_id3),
        .sel_ready(sel_ready3), .proj_reset(proj_reset3), .active_valid(active_valid3),
        .active_id(active_id3), .busy(busy3), .sel_err(sel_err3)
    );

    typedef struct {
        logic       v;
        logic [1:0] id;
        logic [3:0] pr;
        logic       rdy;
        logic       av;
        logic [1:0] aid;
        logic       bsy;
    } vec_t;

    vec_t vecs[$];
    int   checks   = 0;
    int   failures = 0;

    task automatic chk(input string name, input int idx, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s step=%0d actual=%0h expected=%0h", name, idx, act, exp);
        end
    endtask

    function automatic void push(logic v, logic [1:0] id, logic [3:0] pr, logic rdy,
                                 logic av, logic [1:0] aid, logic bsy);
        vec_t e;
        e.v = v; e.id = id; e.pr = pr; e.rdy = rdy; e.av = av; e.aid = aid; e.bsy = bsy;
        vecs.push_back(e);
    endfunction

    // Accept cycle, S-1 settle cycles, then the release edge; late_at marks when a
    // competing request (late_id) starts being held during the window.
    function automatic void add_switch(logic [1:0] id, logic [3:0] final_pr, int late_at, logic [1:0] late_id);
        push(1'b1, id, 4'hF, 1'b0, 1'b0, 2'd0, 1'b1);
        for (int k = 1; k < S; k++) push(k >= late_at, late_id, 4'hF, 1'b0, 1'b0, 2'd0, 1'b1);
        push(late_at <= S, late_id, final_pr, 1'b1, 1'b1, id, 1'b0);
    endfunction

    function automatic int zeros(logic [3:0] v);
        int z = 0;
        for (int b = 0; b < 4; b++) if (!v[b]) z++;
        return z;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        for (int i = 0; i < 20; i++) push(1'b0, 2'd0, 4'hF, 1'b1, 1'b0, 2'd0, 1'b0);
        add_switch(2'd0, 4'b1110, 99, 2'd0);
        for (int i = 0; i < 3; i++) push(1'b0, 2'd0, 4'b1110, 1'b1, 1'b1, 2'd0, 1'b0);
        add_switch(2'd1, 4'b1101, 3, 2'd2);
        add_switch(2'd2, 4'b1011, 99, 2'd0);
        for (int i = 0; i < 2; i++) push(1'b0, 2'd0, 4'b1011, 1'b1, 1'b1, 2'd2, 1'b0);
        add_switch(2'd2, 4'b1011, 99, 2'd0);
        for (int i = 0; i < 2; i++) push(1'b0, 2'd0, 4'b1011, 1'b1, 1'b1, 2'd2, 1'b0);

        reset = 1'b1; sel_valid = 1'b0; sel_id = 2'd0;
        reset3 = 1'b1; sel_valid3 = 1'b0; sel_id3 = 2'd0;
        tick();
        chk("rst_pr", -1, 8'(proj_reset), 8'hF);
        chk("rst_rdy", -1, 8'(sel_ready), 8'd1);
        chk("rst_av", -1, 8'(active_valid), 8'd0);
        chk("rst_aid", -1, 8'(active_id), 8'd0);
        chk("rst_busy", -1, 8'(busy), 8'd0);
        chk("rst_err", -1, 8'(sel_err), 8'd0);
        @(negedge clk);
        reset = 1'b0; reset3 = 1'b0;

        foreach (vecs[i]) begin
            sel_valid = vecs[i].v;
            sel_id    = vecs[i].id;
            tick();
            chk("pr", i, 8'(proj_reset), 8'(vecs[i].pr));
            chk("rdy", i, 8'(sel_ready), 8'(vecs[i].rdy));
            chk("av", i, 8'(active_valid), 8'(vecs[i].av));
            chk("busy", i, 8'(busy), 8'(vecs[i].bsy));
            chk("err", i, 8'(sel_err), 8'd0);
            if (vecs[i].av) chk("aid", i, 8'(active_id), 8'(vecs[i].aid));
            chk("one_zero_max", i, 8'(zeros(proj_reset) <= 1), 8'd1);
        end
        sel_valid = 1'b0;

        // Async reset while the counter sits at 4.
        sel_valid = 1'b1; sel_id = 2'd1;
        tick();
        sel_valid = 1'b0;
        chk("ar_busy_pre", 0, 8'(busy), 8'd1);
        repeat (3) tick();
        #2 reset = 1'b1;
        #1;
        chk("ar_pr", 0, 8'(proj_reset), 8'hF);
        chk("ar_rdy", 0, 8'(sel_ready), 8'd1);
        chk("ar_busy", 0, 8'(busy), 8'd0);
        chk("ar_av", 0, 8'(active_valid), 8'd0);
        @(negedge clk);
        reset = 1'b0;
        repeat (10) tick();
        chk("ar_idle_pr", 1, 8'(proj_reset), 8'hF);
        chk("ar_idle_av", 1, 8'(active_valid), 8'd0);
        chk("ar_idle_rdy", 1, 8'(sel_ready), 8'd1);
        chk("ar_idle_busy", 1, 8'(busy), 8'd0);

        // Three-project instance: run project 2, then request illegal ID 3.
        sel_valid3 = 1'b1; sel_id3 = 2'd2;
        tick();
        sel_valid3 = 1'b0;
        chk("p3_busy", 0, 8'(busy3), 8'd1);
        repeat (S) tick();
        chk("p3_run_pr", 0, 8'(proj_reset3), 8'b011);
        chk("p3_run_av", 0, 8'(active_valid3), 8'd1);
        chk("p3_run_aid", 0, 8'(active_id3), 8'd2);
        sel_valid3 = 1'b1; sel_id3 = 2'd3;
        tick();
        sel_valid3 = 1'b0;
        chk("oor_pr", 0, 8'(proj_reset3), 8'b111);
        chk("oor_err", 0, 8'(sel_err3), 8'd1);
        chk("oor_av", 0, 8'(active_valid3), 8'd0);
        chk("oor_rdy", 0, 8'(sel_ready3), 8'd1);
        chk("oor_busy", 0, 8'(busy3), 8'd0);
        tick();
        chk("oor_err_end", 1, 8'(sel_err3), 8'd0);
        chk("oor_pr_hold", 1, 8'(proj_reset3), 8'b111);
        chk("oor_idle_rdy", 1, 8'(sel_ready3), 8'd1);
        chk("oor_idle_busy", 1, 8'(busy3), 8'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/project_select_ctrl.md
# project_select_ctrl

Upstream control stage for the multi-project harness: it generates the per-project reset vector that the harness uses both to reset each project and to pick which project's GPIOs are routed. A select request arrives over a valid/ready handshake. The block then holds every project in reset for a fixed settle window, and finally releases only the chosen project. This keeps the harness from seeing a two-project overlap and makes every switch start the new project from a clean reset.

## Interface
- `NUM_PROJECTS`, default 4: number of projects, which sets the width of `proj_reset`; legal range is 2–8.
- `SETTLE_CYCLES`, default 8: number of cycles all projects are held in reset during a switch; must be ≥1.
- `ID_W`, default `$clog2(NUM_PROJECTS)`: width of the project ID.

- `clk`  in  1  single clock for the whole block.
- `reset`  in  1  asynchronous, active-high reset.
- `sel_valid`  in  1  a select request is present.
- `sel_id`  in  ID_W  requested project; any value ≥ NUM_PROJECTS means deselect all projects.
- `sel_ready`  out  1  the block can accept a request.
- `proj_reset`  out  NUM_PROJECTS  active-high per-project reset, fed directly to the harness reset vector.
- `active_valid`  out  1  a project is currently released and running.
- `active_id`  out  ID_W  ID of the running project; valid only while `active_valid` is high.
- `busy`  out  1  a switch is in progress.
- `sel_err`  out  1  one-cycle pulse when an out-of-range ID is accepted.

## Operation
- **States:**
  - IDLE: no project running.
  - SWITCH: settle window in progress.
  - RUN: one project released.
- **Reset values:**
  - State is IDLE.
  - `proj_reset` is all ones.
  - `sel_ready`=1.
  - `active_valid`=0, `active_id`=0, `busy`=0, `sel_err`=0.
  - Settle counter is 0.
- **Handshake:**
  - `sel_ready` is 1 in IDLE and RUN, and 0 in SWITCH.
  - A request is accepted on a rising edge where `sel_valid` and `sel_ready` are both 1.
  - `sel_valid` held during SWITCH is ignored, not queued; the requester must keep it asserted until accepted.
- **IDLE or RUN, accept with in-range ID:**
  - Latch the ID and drive `proj_reset` to all ones.
  - Clear `active_valid`, set `busy`, and load the counter with SETTLE_CYCLES-1.
  - Go to SWITCH.
- **Accepting the same ID that is already running:** performs a full re-reset switch, not a no-op.
- **IDLE or RUN, accept with out-of-range ID:**
  - Drive `proj_reset` to all ones, clear `active_valid`, and pulse `sel_err` for one cycle.
  - Go to IDLE without entering SWITCH.
- **SWITCH:**
  - Decrement the counter each cycle.
  - When the counter is 0, on the next edge set `proj_reset` to all ones except bit `id`, which is cleared.
  - On that same edge, set `active_valid`=1, set `active_id`=id, clear `busy`, and go to RUN.
- **RUN:** outputs are held stable until the next accepted request.
- **Invariant:** at most one bit of `proj_reset` is 0 in every cycle. The all-ones value is the only state allowed between two different selections.
- **Async reset mid-SWITCH or mid-RUN:** all outputs return to their reset values immediately. The latched request is discarded.

## Timing
- All outputs are registered, and `sel_ready` is decoded from the state register, so no input reaches an output in the same cycle.
- Accept happens at edge T. `proj_reset` becomes all ones after edge T, and `busy`=1 after edge T.
- Release happens at edge T+SETTLE_CYCLES. The selected project sees exactly SETTLE_CYCLES cycles of asserted reset following T.
- `sel_ready` returns to 1 after edge T+SETTLE_CYCLES, so the next request can be accepted at the earliest on edge T+SETTLE_CYCLES+1.
- An out-of-range accept at T gives `proj_reset` all ones, `sel_err`=1 for cycle T..T+1 only, and `sel_ready` remains 1.
- The counter is `$clog2(SETTLE_CYCLES+1)` bits wide and never wraps, because it is only loaded on accept.

## Test plan
- **Reset then idle:** deassert `reset` and hold `sel_valid`=0 for 20 cycles → `proj_reset`=4'b1111, `sel_ready`=1, `active_valid`=0, `busy`=0 throughout.
- **Select project 0 (SETTLE_CYCLES=8):** accept `sel_id`=0 at edge T → `proj_reset`=4'b1111 for T..T+8, then 4'b1110 from T+8; `active_id`=0; `busy` is high for exactly 8 cycles.
- **Switch from 0 to 1 while running:** accept `sel_id`=1 → `proj_reset` goes 4'b1110→1111 for 8 cycles→1101; the bench asserts that no cycle ever has two zero bits.
- **Request during SWITCH:** assert `sel_valid` with `sel_id`=2 three cycles after accepting `sel_id`=1 → `sel_ready`=0 and the request is ignored; the block lands on 4'b1101, then accepts ID 2 after `sel_ready` rises.
- **Out-of-range ID:** with NUM_PROJECTS=3 (`ID_W`=2) running project 2, accept `sel_id`=3 → `proj_reset`=3'b111 on the next edge, `sel_err` is a single-cycle pulse, `active_valid`=0, and the block returns to IDLE.
- **Async reset mid-SWITCH:** assert `reset` between clock edges at counter=4 → outputs take reset values before the next edge; after release, the block sits in IDLE with `proj_reset` all ones.
